alu_seq_ctrl: RTL and testbench

- Multi-cycle control FSM that sequences the RV32I execution datapath around the ALU.
- Drives ALUOp/ALUSrc, register-file write, memory request and PC-update strobes, one instruction at a time.
- Consumes the opcode from the instruction register, the ALU branch flag `zero`, and ready handshakes from instruction/data memory.
- Sits between the memory interfaces and the existing combinational ALU/regfile/PC datapath.

---
 rtl/alu_seq_pkg.sv | 61 ++++++
 rtl/alu_seq_ctrl_if.sv | 36 +++
 rtl/alu_seq_wait_timer.sv | 37 +++
 rtl/alu_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle sequencing controller.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_e;

    // Instruction class latched in DECODE so later states need not look at the opcode.
    typedef enum logic [2:0] {
        ClsR,
        ClsI,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal
    } cls_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

    typedef struct packed {
        logic legal;
        cls_e cls;
    } dec_t;

    function automatic dec_t decode_opcode(input logic [6:0] opc);
        dec_t d;
        d.legal = 1'b1;
        d.cls   = ClsR;
        case (opc)
            OPC_R:      d.cls = ClsR;
            OPC_I:      d.cls = ClsI;
            OPC_LOAD:   d.cls = ClsLoad;
            OPC_STORE:  d.cls = ClsStore;
            OPC_BRANCH: d.cls = ClsBranch;
            OPC_JAL:    d.cls = ClsJal;
            default:    d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Control/handshake bundle between the sequencer and the memories/datapath.
// master: the sequencer; slave: the surrounding datapath and memories.
interface alu_seq_ctrl_if;

    logic       start;
    logic [6:0] opcode;
    logic       zero;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_write;
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_write;
    logic       pc_src;
    logic       busy;
    logic       trap;
    logic [1:0] trap_cause;

    modport master (
        input  start, opcode, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, ALUOp, ALUSrc, mem_read, mem_write, mem_to_reg,
               reg_write, pc_write, pc_src, busy, trap, trap_cause
    );

    modport slave (
        output start, opcode, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, ALUOp, ALUSrc, mem_read, mem_write, mem_to_reg,
               reg_write, pc_write, pc_src, busy, trap, trap_cause
    );

endinterface

// File: rtl/alu_seq_wait_timer.sv
// Saturating wait-cycle counter shared by the FETCH and MEM handshakes.
module alu_seq_wait_timer #(
    parameter int unsigned WaitMax = 255,
    parameter int unsigned WaitW   = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic sat_hit_o
);

    logic [WaitW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and hold at WaitMax.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != WaitW'(WaitMax))) begin
            cnt_d = cnt_q + WaitW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High during the WaitMax-th consecutive un-acknowledged cycle.
    assign sat_hit_o = (cnt_q >= WaitW'(WaitMax - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle RV32I control sequencer around the ALU/regfile/PC datapath.
// Optional macro ALU_SEQ_PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_ctrl_if.master bus
`ifdef ALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]   cycle_cnt,
    output logic [31:0]   instret_cnt
`endif
);

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [1:0] cause_q, cause_d;
    logic       waiting;
    logic       sat_hit;
    dec_t       dec;

    logic       imem_req, ir_write, alu_src, mem_read, mem_write, mem_to_reg;
    logic       reg_write, pc_write, pc_src, busy, trap;
    logic [1:0] alu_op;

    assign dec = decode_opcode(bus.opcode);

    // A handshake cycle without acknowledge advances the timer; anything else clears it.
    assign waiting = ((state_q == StFetch) && !bus.imem_ready) ||
                     ((state_q == StMem) && !bus.dmem_ready);

    alu_seq_wait_timer #(
        .WaitMax (WAIT_MAX),
        .WaitW   (WAIT_W)
    ) u_wait_timer (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .clear_i   (!waiting),
        .en_i      (waiting),
        .sat_hit_o (sat_hit)
    );

    // Next-state and strobe decode; only ir_write, pc_src and the MEM handshake look at inputs.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        cause_d    = cause_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        alu_op     = ALUOP_ADD;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        busy       = 1'b1;
        trap       = 1'b0;
        case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = StDecode;
                end else if (sat_hit) begin
                    state_d = StTrap;
                    cause_d = CAUSE_IMEM_TO;
                end
            end
            StDecode: begin
                if (dec.legal) begin
                    cls_d   = dec.cls;
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsI: begin
                        alu_op  = ALUOP_FUNCT;
                        alu_src = 1'b1;
                        state_d = StWb;
                    end
                    ClsLoad, ClsStore: begin
                        alu_src = 1'b1;
                        state_d = StMem;
                    end
                    ClsBranch: begin
                        alu_op   = ALUOP_BR;
                        pc_write = 1'b1;
                        pc_src   = bus.zero;
                        state_d  = StFetch;
                    end
                    ClsJal: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        state_d   = StFetch;
                    end
                    default: begin
                        alu_op  = ALUOP_FUNCT;
                        state_d = StWb;
                    end
                endcase
            end
            StMem: begin
                alu_src   = 1'b1;
                mem_read  = (cls_q == ClsLoad);
                mem_write = (cls_q == ClsStore);
                if (bus.dmem_ready) begin
                    if (cls_q == ClsLoad) begin
                        state_d = StWb;
                    end else begin
                        // Store retires here, so its single PC update happens on the ack.
                        pc_write = 1'b1;
                        state_d  = StFetch;
                    end
                end else if (sat_hit) begin
                    state_d = StTrap;
                    cause_d = CAUSE_DMEM_TO;
                end
            end
            StWb: begin
                alu_op     = (cls_q == ClsLoad) ? ALUOP_ADD : ALUOP_FUNCT;
                alu_src    = (cls_q != ClsR);
                mem_to_reg = (cls_q == ClsLoad);
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                state_d    = StFetch;
            end
            StTrap: begin
                busy = 1'b0;
                trap = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State, instruction class and trap cause registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cls_q   <= ClsR;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.ir_write   = ir_write;
    assign bus.ALUOp      = alu_op;
    assign bus.ALUSrc     = alu_src;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.reg_write  = reg_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.busy       = busy;
    assign bus.trap       = trap;
    assign bus.trap_cause = cause_q;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0] cycle_q, cycle_d, instret_q, instret_d;

    // Free-running busy-cycle and retired-instruction counts, wrapping at 2^32.
    always_comb begin
        cycle_d   = cycle_q + (busy ? 32'd1 : 32'd0);
        instret_d = instret_q + (pc_write ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with WAIT_MAX=4; optional counters checked under
// ALU_SEQ_PERF_CNT_EN.
module tb_alu_seq_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

`ifdef ALU_SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;
`endif

    alu_seq_ctrl_if bus_if ();

    alu_seq_ctrl #(
        .WAIT_MAX (4),
        .WAIT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef ALU_SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed strobes, packed in the same order as ev() below.
    logic [14:0] obs;
    assign obs = {bus_if.imem_req, bus_if.ir_write, bus_if.ALUOp, bus_if.ALUSrc,
                  bus_if.mem_read, bus_if.mem_write, bus_if.mem_to_reg, bus_if.reg_write,
                  bus_if.pc_write, bus_if.pc_src, bus_if.busy, bus_if.trap,
                  bus_if.trap_cause};

    function automatic logic [14:0] ev(input logic req, input logic irw, input logic [1:0] op,
                                       input logic src, input logic mrd, input logic mwr,
                                       input logic m2r, input logic rw, input logic pcw,
                                       input logic pcs, input logic bsy, input logic trp,
                                       input logic [1:0] cause);
        return {req, irw, op, src, mrd, mwr, m2r, rw, pcw, pcs, bsy, trp, cause};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock, then step just past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let freshly driven inputs settle, then compare the strobe vector.
    task automatic cv(input string tag, input logic [14:0] e);
        #1;
        chk(tag, {17'd0, obs}, {17'd0, e});
    endtask

    logic [14:0] e_idle, e_fetch, e_fwait, e_dec, e_ex_r, e_wb_r, e_ex_addr, e_mem_ld;
    logic [14:0] e_wb_ld, e_br_t, e_br_n, e_jal, e_mem_st, e_mem_stw, e_ex_i, e_wb_i;
    logic [14:0] e_trap_ill, e_trap_imem, e_trap_dmem;

    initial begin
        total = 0;
        bad   = 0;
        //                 req irw op     src rd wr m2r rw pcw pcs bsy trp cause
        e_idle      = 15'd0;
        e_fetch     = ev(1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_fwait     = ev(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_dec       = ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_ex_r      = ev(0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_wb_r      = ev(0, 0, 2'b10, 0, 0, 0, 0, 1, 1, 0, 1, 0, 2'b00);
        e_ex_addr   = ev(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_mem_ld    = ev(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_wb_ld     = ev(0, 0, 2'b00, 1, 0, 0, 1, 1, 1, 0, 1, 0, 2'b00);
        e_br_t      = ev(0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 1, 1, 0, 2'b00);
        e_br_n      = ev(0, 0, 2'b01, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00);
        e_jal       = ev(0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1, 1, 0, 2'b00);
        e_mem_st    = ev(0, 0, 2'b00, 1, 0, 1, 0, 0, 1, 0, 1, 0, 2'b00);
        e_mem_stw   = ev(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00);
        e_ex_i      = ev(0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
        e_wb_i      = ev(0, 0, 2'b10, 1, 0, 0, 0, 1, 1, 0, 1, 0, 2'b00);
        e_trap_ill  = ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01);
        e_trap_imem = ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10);
        e_trap_dmem = ev(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11);

        rst_n             = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.opcode     = 7'd0;
        bus_if.zero       = 1'b0;
        bus_if.imem_ready = 1'b1;
        bus_if.dmem_ready = 1'b1;
        cyc();
        cyc();
        cv("reset", e_idle);
`ifdef ALU_SEQ_PERF_CNT_EN
        chk("cycle_cnt_reset", cycle_cnt, 32'd0);
        chk("instret_cnt_reset", instret_cnt, 32'd0);
`endif

        // R-type, zero-wait memory: pc_write lands on the 4th cycle.
        rst_n = 1'b1; bus_if.start = 1'b1; bus_if.opcode = 7'b0110011;
        cyc(); bus_if.start = 1'b0; cv("r_fetch", e_fetch);
        cyc(); cv("r_decode", e_dec);
        cyc(); cv("r_exec", e_ex_r);
        cyc(); cv("r_wb", e_wb_r);

        // Load with dmem_ready delayed 3 cycles; ack arrives as the timer saturates.
        cyc(); bus_if.opcode = 7'b0000011; bus_if.dmem_ready = 1'b0; cv("ld_fetch", e_fetch);
        cyc(); cv("ld_decode", e_dec);
        cyc(); cv("ld_exec", e_ex_addr);
        cyc(); cv("ld_mem1", e_mem_ld);
        cyc(); cv("ld_mem2", e_mem_ld);
        cyc(); cv("ld_mem3", e_mem_ld);
        cyc(); bus_if.dmem_ready = 1'b1; cv("ld_mem4_ack", e_mem_ld);
        cyc(); cv("ld_wb", e_wb_ld);

        // Branch taken then not taken.
        cyc(); bus_if.opcode = 7'b1100011; bus_if.zero = 1'b1; cv("br1_fetch", e_fetch);
        cyc(); cv("br1_decode", e_dec);
        cyc(); cv("br1_exec_taken", e_br_t);
        cyc(); bus_if.zero = 1'b0; cv("br2_fetch", e_fetch);
        cyc(); cv("br2_decode", e_dec);
        cyc(); cv("br2_exec_not_taken", e_br_n);

        // jal links and redirects in EXEC.
        cyc(); bus_if.opcode = 7'b1101111; cv("jal_fetch", e_fetch);
        cyc(); cv("jal_decode", e_dec);
        cyc(); cv("jal_exec", e_jal);

        // Store retires in MEM on the ack.
        cyc(); bus_if.opcode = 7'b0100011; cv("st_fetch", e_fetch);
        cyc(); cv("st_decode", e_dec);
        cyc(); cv("st_exec", e_ex_addr);
        cyc(); cv("st_mem", e_mem_st);

        // I-arith uses the immediate.
        cyc(); bus_if.opcode = 7'b0010011; cv("i_fetch", e_fetch);
        cyc(); cv("i_decode", e_dec);
        cyc(); cv("i_exec", e_ex_i);
        cyc(); cv("i_wb", e_wb_i);

        // imem ack on the 4th waiting cycle still succeeds; then an illegal opcode traps.
        cyc(); bus_if.imem_ready = 1'b0; cv("fw_wait1", e_fwait);
        cyc(); cv("fw_wait2", e_fwait);
        cyc(); cv("fw_wait3", e_fwait);
        cyc(); bus_if.imem_ready = 1'b1; bus_if.opcode = 7'b1111111; cv("fw_ack4", e_fetch);
        cyc(); cv("ill_decode", e_dec);
        cyc(); bus_if.start = 1'b1; cv("ill_trap", e_trap_ill);
        cyc(); cv("trap_ignores_start", e_trap_ill);

        // Reset clears the trap.
        rst_n = 1'b0; bus_if.start = 1'b0;
        cyc(); cv("reset_from_trap", e_idle);

        // imem never acks: trap after exactly 4 FETCH cycles.
        rst_n = 1'b1; bus_if.start = 1'b1; bus_if.opcode = 7'b0110011; bus_if.imem_ready = 1'b0;
        cyc(); bus_if.start = 1'b0; cv("ito_fetch1", e_fwait);
        cyc(); cv("ito_fetch2", e_fwait);
        cyc(); cv("ito_fetch3", e_fwait);
        cyc(); cv("ito_fetch4", e_fwait);
        cyc(); cv("ito_trap", e_trap_imem);

        // dmem never acks on a store: trap after 4 MEM cycles.
        rst_n = 1'b0;
        cyc(); cv("reset_before_dto", e_idle);
        rst_n = 1'b1; bus_if.start = 1'b1; bus_if.opcode = 7'b0100011;
        bus_if.imem_ready = 1'b1; bus_if.dmem_ready = 1'b0;
        cyc(); bus_if.start = 1'b0; cv("dto_fetch", e_fetch);
        cyc(); cv("dto_decode", e_dec);
        cyc(); cv("dto_exec", e_ex_addr);
        cyc(); cv("dto_mem1", e_mem_stw);
        cyc(); cv("dto_mem2", e_mem_stw);
        cyc(); cv("dto_mem3", e_mem_stw);
        cyc(); cv("dto_mem4", e_mem_stw);
        cyc(); cv("dto_trap", e_trap_dmem);

        // Reset in the middle of a pending store.
        rst_n = 1'b0;
        cyc(); rst_n = 1'b1; bus_if.start = 1'b1; cv("reset_before_mid", e_idle);
        cyc(); bus_if.start = 1'b0; cv("mid_fetch", e_fetch);
        cyc(); cv("mid_decode", e_dec);
        cyc(); cv("mid_exec", e_ex_addr);
        cyc(); rst_n = 1'b0; cv("mid_mem_pending", e_mem_stw);
        cyc(); cv("mid_reset_idle", e_idle);

`ifdef ALU_SEQ_PERF_CNT_EN
        // Three back-to-back R-types: 12 busy cycles, 3 retirements.
        rst_n = 1'b1; bus_if.start = 1'b1; bus_if.opcode = 7'b0110011; bus_if.dmem_ready = 1'b1;
        cyc(); bus_if.start = 1'b0;
        repeat (12) cyc();
        #1;
        chk("instret_cnt_3r", instret_cnt, 32'd3);
        chk("cycle_cnt_3r", cycle_cnt, 32'd12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
